// File: rtl/div_seq_pkg.sv
// div_seq shared defines: divider FSM state codes and result strobe levels.
// Imported by the divider and its bundle interface.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_seq_if.sv
// EX-stage divider bundle: operands and controls from the pipeline,
// {remainder, quotient}, the ready strobe and the stall request back.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               signed_div;
    logic               start;
    logic               annul;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               stall;

    modport master (
        output a, b, signed_div, start, annul,
        input  result, ready, stall
    );

    modport slave (
        input  a, b, signed_div, start, annul,
        output result, ready, stall
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// Produces {remainder, quotient} for the HI/LO write path.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_seq_if.slave   bus
);

    localparam int W  = WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    div_state_e    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  dvd;
    logic [W-1:0]  dvs;
    logic [W-1:0]  rem;
    logic          qneg;
    logic          rneg;

    logic [W:0]    trial;
    logic [W-1:0]  nrem;
    logic [W-1:0]  nq;

    function automatic logic [W-1:0] neg_abs(
        input logic [W-1:0] x,
        input logic         n
    );
        return n ? -x : x;
    endfunction

    // The dividend register doubles as the quotient: each step shifts
    // one dividend bit out of the top and one quotient bit in at the bottom.
    always_comb begin
        trial = {rem, dvd[W-1]} - {1'b0, dvs};
        nrem  = {rem[W-2:0], dvd[W-1]};
        nq    = {dvd[W-2:0], 1'b0};
        if (!trial[W]) begin
            nrem = trial[W-1:0];
            nq   = {dvd[W-2:0], 1'b1};
        end
    end

    assign bus.stall = (state == DIV_ON) ||
                       (state == DIV_ZERO) ||
                       ((state == DIV_IDLE) && bus.start && !bus.annul);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DIV_IDLE;
            bus.result <= '0;
            bus.ready  <= DIV_RESULT_NOT_READY;
            cnt        <= '0;
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            qneg       <= 1'b0;
            rneg       <= 1'b0;
        end else begin
            bus.ready <= DIV_RESULT_NOT_READY;
            unique case (state)
                DIV_IDLE: begin
                    if (bus.start && !bus.annul) begin
                        dvd  <= neg_abs(bus.a, bus.signed_div & bus.a[W-1]);
                        dvs  <= neg_abs(bus.b, bus.signed_div & bus.b[W-1]);
                        rem  <= '0;
                        cnt  <= '0;
                        qneg <= bus.signed_div & (bus.a[W-1] ^ bus.b[W-1]);
                        rneg <= bus.signed_div & bus.a[W-1];
                        state <= (bus.b == '0) ? DIV_ZERO : DIV_ON;
                    end
                end
                DIV_ZERO: begin
                    if (bus.annul) begin
                        state <= DIV_IDLE;
                    end else begin
                        bus.result <= '0;
                        bus.ready  <= DIV_RESULT_READY;
                        state      <= DIV_END;
                    end
                end
                DIV_ON: begin
                    if (bus.annul) begin
                        state <= DIV_IDLE;
                    end else begin
                        rem <= nrem;
                        dvd <= nq;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            bus.result <= {neg_abs(nrem, rneg),
                                           neg_abs(nq, qneg)};
                            bus.ready  <= DIV_RESULT_READY;
                            state      <= DIV_END;
                        end
                    end
                end
                DIV_END: begin
                    state <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq.
// Hand-computed vectors cover latency, signs, overflow, div-by-zero, annul, reset.
module tb_div_seq;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;

    div_seq_if #(.WIDTH(32)) bus ();

    div_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a divide in the current IDLE cycle T and follow it to ready.
    task automatic run_div(input string tag, input logic [31:0] av,
                           input logic [31:0] bv, input logic sg,
                           input logic [63:0] exp, input int lat,
                           output int rcyc);
        int  n;
        bit  stall_ok;
        bus.a          = av;
        bus.b          = bv;
        bus.signed_div = sg;
        bus.start      = 1'b1;
        #1;
        check({tag, "_stall_T"}, 64'(bus.stall), 64'd1);
        n        = 0;
        stall_ok = 1'b1;
        while (!bus.ready && n < 40) begin
            step();
            n++;
            if (!bus.ready && !bus.stall) stall_ok = 1'b0;
        end
        rcyc = cyc;
        check({tag, "_ready"}, 64'(bus.ready), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_stall_end"}, 64'(bus.stall), 64'd0);
        check({tag, "_stall_held"}, 64'(stall_ok), 64'd1);
        bus.start = 1'b0;
        step();
        check({tag, "_pulse_1cyc"}, 64'(bus.ready), 64'd0);
    endtask

    initial begin
        int  r1;
        int  r2;
        bit  seen;
        tests          = 0;
        fails          = 0;
        rst            = 1'b1;
        bus.a          = '0;
        bus.b          = '0;
        bus.signed_div = 1'b0;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_result", bus.result, 64'd0);
        check("rst_ready", 64'(bus.ready), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        rst = 1'b0;

        run_div("udiv_100_7", 32'd100, 32'd7, 1'b0,
                64'h00000002_0000000E, 33, r1);
        run_div("divzero", 32'd5, 32'd0, 1'b0,
                64'h0, 2, r1);
        run_div("sdiv_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1,
                64'hFFFFFFFF_FFFFFFFD, 33, r1);
        run_div("sdiv_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1,
                64'h00000000_80000000, 33, r1);
        run_div("udiv_large", 32'h80000000, 32'hFFFFFFFF, 1'b0,
                64'h80000000_00000000, 33, r1);
        run_div("sdiv_m100_7", 32'hFFFFFF9C, 32'd7, 1'b1,
                64'hFFFFFFFE_FFFFFFF2, 33, r1);

        // Annul at T+10 while in ON.
        bus.a          = 32'd1000;
        bus.b          = 32'd3;
        bus.signed_div = 1'b0;
        bus.start      = 1'b1;
        for (int i = 0; i < 10; i++) step();
        bus.start = 1'b0;
        bus.annul = 1'b1;
        step();
        bus.annul = 1'b0;
        #1;
        check("annul_stall", 64'(bus.stall), 64'd0);
        check("annul_ready", 64'(bus.ready), 64'd0);
        check("annul_result_kept", bus.result, 64'hFFFFFFFE_FFFFFFF2);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.ready) seen = 1'b1;
        end
        check("annul_no_ready", 64'(seen), 64'd0);

        // Reset at T+20 of a fresh divide.
        bus.start = 1'b1;
        for (int i = 0; i < 20; i++) step();
        rst       = 1'b1;
        bus.start = 1'b0;
        step();
        check("midrst_result", bus.result, 64'd0);
        check("midrst_ready", 64'(bus.ready), 64'd0);
        check("midrst_stall", 64'(bus.stall), 64'd0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.ready) seen = 1'b1;
        end
        check("midrst_no_ready", 64'(seen), 64'd0);

        // Back-to-back pair with a single idle bubble.
        run_div("b2b_9_3", 32'd9, 32'd3, 1'b0,
                64'h00000000_00000003, 33, r1);
        run_div("b2b_10_4", 32'd10, 32'd4, 1'b0,
                64'h00000002_00000002, 33, r2);
        check("b2b_spacing", 64'(r2 - r1), 64'd34);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
